addsub_share_arbiter: RTL and testbench

- Shares one registered 4-bit adder/subtractor between two requesters.
- Each requester presents two operands and an add/sub select over a valid/ready handshake.
- The block grants requesters round-robin, sequences the operation through a 3-state FSM, and returns the result on a single response channel tagged with the requester ID.
- It sits between the control logic that issues arithmetic requests and the 4-bit add/sub datapath.

---
 rtl/addsub_share_arbiter_if.sv | 40 ++++
 rtl/addsub_share_arbiter.sv | 126 ++++++++++++
 tb/tb_addsub_share_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/addsub_share_arbiter_if.sv
// Request/response bundle for the shared add/sub unit. The master side is the
// requesters plus the response consumer; the slave side is the arbiter.
interface addsub_share_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_sub;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_sub;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_cout;
    logic             rsp_ovf;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        output req1_valid, req1_a, req1_b, req1_sub,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_ovf
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_sub,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_ovf
    );
endinterface

// File: rtl/addsub_share_arbiter.sv
// Round-robin arbiter sharing one registered add/sub unit between two
// requesters; IDLE -> EXEC -> RESP, one operation in flight at a time.
module addsub_share_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    addsub_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sub;
    logic             r_id;

    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_cout;
    logic             r_rsp_ovf;

    logic             w_grant_id;
    logic             w_idle;
    logic             w_ready0;
    logic             w_ready1;
    logic             w_accept;
    logic [WIDTH-1:0] w_a_sel;
    logic [WIDTH-1:0] w_b_sel;
    logic             w_sub_sel;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;
    logic             w_carry_into_msb;

    // With both requesters pending, the one not served last wins.
    always_comb begin
        w_grant_id = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant_id = ~r_last_grant;
        end
    end

    // Ready is gated by rst so it reads 0 for the whole reset interval.
    assign w_idle   = (r_state == S_IDLE) && !rst;
    assign w_ready0 = w_idle && bus.req0_valid && !w_grant_id;
    assign w_ready1 = w_idle && bus.req1_valid &&  w_grant_id;
    assign w_accept = w_ready0 || w_ready1;

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;

    always_comb begin
        w_a_sel   = bus.req0_a;
        w_b_sel   = bus.req0_b;
        w_sub_sel = bus.req0_sub;
        if (w_grant_id) begin
            w_a_sel   = bus.req1_a;
            w_b_sel   = bus.req1_b;
            w_sub_sel = bus.req1_sub;
        end
    end

    // Subtraction as A + ~B + 1; the MSB carry-in is recovered from the MSB sum bit.
    assign w_b_eff          = r_b ^ {WIDTH{r_sub}};
    assign w_sum            = {1'b0, r_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, r_sub};
    assign w_carry_into_msb = w_sum[WIDTH-1] ^ r_a[WIDTH-1] ^ w_b_eff[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_sub        <= 1'b0;
            r_id         <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_cout   <= 1'b0;
            r_rsp_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a          <= w_a_sel;
                        r_b          <= w_b_sel;
                        r_sub        <= w_sub_sel;
                        r_id         <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_result <= w_sum[WIDTH-1:0];
                    r_rsp_cout   <= w_sum[WIDTH];
                    r_rsp_ovf    <= w_carry_into_msb ^ w_sum[WIDTH];
                    r_rsp_id     <= r_id;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_cout   = r_rsp_cout;
    assign bus.rsp_ovf    = r_rsp_ovf;
endmodule

// File: tb/tb_addsub_share_arbiter.sv
// Scoreboard bench for addsub_share_arbiter: directed requests push expected
// responses; an independent monitor pops and compares each accepted response.
module tb_addsub_share_arbiter;
    typedef logic [6:0] rsp_t; // {id, result[3:0], cout, ovf}

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    rsp_t sb[$];

    addsub_share_arbiter_if #(.WIDTH(4)) ifc();

    addsub_share_arbiter #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every accepted response must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && ifc.rsp_valid && ifc.rsp_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_rsp: got id=%0d result=%0d cout=%0d ovf=%0d expected none",
                         ifc.rsp_id, ifc.rsp_result, ifc.rsp_cout, ifc.rsp_ovf);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                check("rsp_fields", {ifc.rsp_id, ifc.rsp_result, ifc.rsp_cout, ifc.rsp_ovf}, e);
                $display("rsp id=%0d result=%0d cout=%0d ovf=%0d (expected 0x%0h)",
                         ifc.rsp_id, ifc.rsp_result, ifc.rsp_cout, ifc.rsp_ovf, e);
            end
        end
    end

    task automatic drive_req(input bit id, input bit v, input logic [3:0] a, input logic [3:0] b, input bit s);
        if (id) begin
            ifc.req1_valid = v; ifc.req1_a = a; ifc.req1_b = b; ifc.req1_sub = s;
        end else begin
            ifc.req0_valid = v; ifc.req0_a = a; ifc.req0_b = b; ifc.req0_sub = s;
        end
    endtask

    function automatic logic rdy(input bit id);
        return id ? ifc.req1_ready : ifc.req0_ready;
    endfunction

    task automatic wait_ready(input bit id, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdy(id)) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("drain_queue_empty", sb.size(), 0);
    endtask

    task automatic do_op(input bit id, input logic [3:0] a, input logic [3:0] b, input bit s,
                         input logic [3:0] eres, input bit ecout, input bit eovf);
        bit ok;
        @(posedge clk); #1;
        drive_req(id, 1'b1, a, b, s);
        wait_ready(id, ok);
        check("grant_seen", ok, 1);
        check("other_ready_low", rdy(~id), 0);
        sb.push_back({id, eres, ecout, eovf});
        $display("req id=%0d a=%0d b=%0d sub=%0d", id, a, b, s);
        @(posedge clk); #1;
        drive_req(id, 1'b0, ~a, ~b, ~s);
        @(negedge clk);
        check("exec_rsp_valid_low", ifc.rsp_valid, 0);
        check("exec_readies_low", {ifc.req0_ready, ifc.req1_ready}, 0);
        @(negedge clk);
        check("rsp_valid_at_t2", ifc.rsp_valid, 1);
        drain();
    endtask

    initial begin
        bit ok;
        int gid[$];
        int gcyc[$];

        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int gid[$];
        int gcyc[$];

        ifc.rsp_ready = 1'b1;
        drive_req(0, 1'b1, 4'd3, 4'd5, 1'b0);
        drive_req(1, 1'b1, 4'd2, 4'd5, 1'b1);
        #3;
        check("reset_outputs", {ifc.rsp_valid, ifc.rsp_id, ifc.rsp_result, ifc.rsp_cout, ifc.rsp_ovf}, 0);
        check("reset_readies", {ifc.req0_ready, ifc.req1_ready}, 0);
        drive_req(0, 1'b0, 4'd0, 4'd0, 1'b0);
        drive_req(1, 1'b0, 4'd0, 4'd0, 1'b0);
        @(posedge clk); #1 rst = 1'b0;

        // Directed arithmetic: overflow, borrow, unsigned wrap, signed underflow
        do_op(0, 4'd3,  4'd5, 1'b0, 4'd8,  1'b0, 1'b1);
        do_op(1, 4'd2,  4'd5, 1'b1, 4'd13, 1'b0, 1'b0);
        do_op(0, 4'd15, 4'd1, 1'b0, 4'd0,  1'b1, 1'b0);
        do_op(0, 4'd8,  4'd1, 1'b1, 4'd7,  1'b1, 1'b1);

        // Simultaneous requests after a fresh reset: grants alternate 0,1,0,1
        @(posedge clk); #1 rst = 1'b1;
        drive_req(0, 1'b1, 4'd6, 4'd1, 1'b0);
        drive_req(1, 1'b1, 4'd4, 4'd4, 1'b1);
        for (int k = 0; k < 2; k++) begin
            sb.push_back({1'b0, 4'd7, 1'b0, 1'b0});
            sb.push_back({1'b1, 4'd0, 1'b1, 1'b0});
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 40 && gid.size() < 4; i++) begin
            @(negedge clk);
            if (ifc.req0_ready) begin gid.push_back(0); gcyc.push_back(cyc); end
            else if (ifc.req1_ready) begin gid.push_back(1); gcyc.push_back(cyc); end
        end
        @(posedge clk); #1;
        drive_req(0, 1'b0, 4'd0, 4'd0, 1'b0);
        drive_req(1, 1'b0, 4'd0, 4'd0, 1'b0);
        check("rr_grant_count", gid.size(), 4);
        for (int k = 0; k < gid.size(); k++) begin
            check("rr_grant_order", gid[k], k % 2);
            if (k > 0) check("rr_accept_spacing", gcyc[k] - gcyc[k-1], 3);
        end
        drain();

        // Backpressure in RESP with req1 waiting
        @(posedge clk); #1;
        ifc.rsp_ready = 1'b0;
        drive_req(0, 1'b1, 4'd1, 4'd2, 1'b0);
        wait_ready(0, ok);
        check("bp_grant0", ok, 1);
        sb.push_back({1'b0, 4'd3, 1'b0, 1'b0});
        @(posedge clk); #1;
        drive_req(0, 1'b0, 4'd0, 4'd0, 1'b0);
        drive_req(1, 1'b1, 4'd5, 4'd5, 1'b0);
        @(negedge clk);
        check("bp_exec_ready1_low", ifc.req1_ready, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_stable", {ifc.rsp_valid, ifc.rsp_id, ifc.rsp_result, ifc.rsp_cout, ifc.rsp_ovf},
                  {1'b1, 1'b0, 4'd3, 1'b0, 1'b0});
            check("bp_readies_low", {ifc.req0_ready, ifc.req1_ready}, 0);
        end
        @(posedge clk); #1 ifc.rsp_ready = 1'b1;
        sb.push_back({1'b1, 4'd10, 1'b0, 1'b1});
        @(negedge clk);
        check("bp_release_resp_ready1_low", ifc.req1_ready, 0);
        @(negedge clk);
        check("bp_req1_granted", ifc.req1_ready, 1);
        @(posedge clk); #1;
        drive_req(1, 1'b0, 4'd0, 4'd0, 1'b0);
        drain();

        // Reset during EXEC discards the operation
        @(posedge clk); #1;
        drive_req(0, 1'b1, 4'd7, 4'd7, 1'b0);
        wait_ready(0, ok);
        check("mid_rst_grant", ok, 1);
        @(posedge clk); #1;
        drive_req(0, 1'b0, 4'd0, 4'd0, 1'b0);
        #2 rst = 1'b1;
        drive_req(0, 1'b1, 4'd9, 4'd3, 1'b0);
        drive_req(1, 1'b1, 4'd1, 4'd1, 1'b0);
        #1;
        check("mid_rst_valid_async", ifc.rsp_valid, 0);
        check("mid_rst_readies", {ifc.req0_ready, ifc.req1_ready}, 0);
        @(negedge clk);
        check("mid_rst_valid_held", ifc.rsp_valid, 0);
        @(posedge clk); #1 rst = 1'b0;
        wait_ready(0, ok);
        check("post_rst_req0_first", ok, 1);
        check("post_rst_req1_waits", ifc.req1_ready, 0);
        sb.push_back({1'b0, 4'd12, 1'b0, 1'b0});
        @(posedge clk); #1;
        drive_req(0, 1'b0, 4'd0, 4'd0, 1'b0);
        wait_ready(1, ok);
        check("post_rst_req1_next", ok, 1);
        sb.push_back({1'b1, 4'd2, 1'b0, 1'b0});
        @(posedge clk); #1;
        drive_req(1, 1'b0, 4'd0, 4'd0, 1'b0);
        drain();
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
